pkt_egress_buffer: RTL and testbench
====================================

Name: pkt_egress_buffer

Overview:
Store-and-forward packet buffer between a packet producer inside um (PGM generator output or the port-3 nic_mux output) and a port transmit FIFO. It accepts 134-bit packet words and holds only complete packets. It releases a packet to the port only when the port FIFO fill (iv_fifo_usedw) guarantees room for a maximum-size packet, so a started packet is never stalled. Oversize, malformed or non-fitting packets are dropped whole and counted.

Parameters:
AW, 8, buffer address width; depth = 2^AW words of 134 bits
MAX_PKT_WORDS, 96, maximum packet length in words; also the minimum free space required to admit a packet
USEDW_THRESH, 32, a packet may start only when iv_fifo_usedw < USEDW_THRESH

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
iv_data  in  134  input word; [133:132] 01=head, 11=middle, 10=tail; [131:128] invalid-byte count of last word; [127:0] payload
i_data_wr  in  1  iv_data valid this cycle
ov_data  out  134  output word, same format
o_data_wr  out  1  ov_data valid this cycle
iv_fifo_usedw  in  7  fill level of downstream port FIFO (128 deep)
i_cnt_rst  in  1  synchronous clear of statistics counters only
ov_pkt_cnt  out  32  packets fully transmitted
ov_drop_cnt  out  32  packets dropped
ov_pkt_avail  out  AW  committed packets waiting in buffer

Behaviour:
- Reset (i_rst=1 at a clock edge): all pointers, states and counters return to 0; ov_data=0, o_data_wr=0, ov_pkt_cnt=0, ov_drop_cnt=0, ov_pkt_avail=0. A packet in flight on the output is abandoned without a tail.
- Pointers: rd_ptr, wr_ptr (working) and wr_commit (start of the current packet). All are AW+1 bits so full and empty are distinguishable. free = 2^AW - (wr_ptr - rd_ptr), modulo arithmetic, so pointer wrap-around is transparent.
- Write FSM states: W_IDLE, W_ACCEPT, W_DROP.
- W_IDLE, wr with head:
  - If free >= MAX_PKT_WORDS: write the word and go to W_ACCEPT.
  - Otherwise: ov_drop_cnt+1 and go to W_DROP.
- W_IDLE, wr with non-head: the word is discarded silently and not counted.
- W_ACCEPT, middle word: write it and increment the word count.
- W_ACCEPT, tail word: write it; wr_commit<=wr_ptr+1; packet committed; go to W_IDLE.
- W_ACCEPT, head word (missing tail): rewind wr_ptr<=wr_commit and ov_drop_cnt+1. The new head is then evaluated exactly as in W_IDLE in the same cycle.
- W_ACCEPT, word count reaches MAX_PKT_WORDS with no tail: rewind, ov_drop_cnt+1, go to W_DROP.
- W_ACCEPT, i_data_wr=0: hold state; gaps inside a packet are permitted.
- W_DROP: discard words until a tail, then go to W_IDLE. A head seen here is evaluated as in W_IDLE.
- Read FSM states: R_IDLE, R_SEND.
- R_IDLE: when ov_pkt_avail>0 and iv_fifo_usedw<USEDW_THRESH, issue a RAM read at rd_ptr and go to R_SEND.
- R_SEND: read one word per cycle with no stalls. RAM read latency is 1, so o_data_wr follows the read enable by one cycle. The output is registered; ov_data=0 whenever o_data_wr=0.
- When the emitted word is a tail: stop reading, ov_pkt_cnt+1, decrement ov_pkt_avail, return to R_IDLE. Consecutive packets have at least one idle cycle between them.
- Latency: tail written at cycle t, committed at t+1, read issued at t+1, first word out at t+2, provided the buffer was empty and usedw is below threshold.
- Simultaneous commit and release in one cycle: ov_pkt_avail is unchanged.
- iv_fifo_usedw is sampled only at packet start. Rising usedw mid-packet does not stall the packet.
- i_cnt_rst clears ov_pkt_cnt and ov_drop_cnt and takes priority over a same-cycle increment. It does not affect data or pointers.
- Counters wrap 0xFFFFFFFF -> 0.

Test Plan:
- Single 4-word packet, usedw=0: input cycles 0-3, tail at cycle 3 -> o_data_wr high cycles 5-8, words identical, ov_pkt_cnt=1, ov_pkt_avail returns to 0.
- Backpressure: usedw=40, 2 packets buffered -> no output and ov_pkt_avail=2. Drop usedw to 31 -> first packet emitted contiguously, then an idle cycle, then the second.
- Oversize: 100-word packet -> nothing output, ov_drop_cnt=1. The following 4-word packet is transmitted intact, proving wr_ptr was rewound.
- Malformed: head, 2 middles, then a new head plus a 4-word packet -> first fragment dropped (ov_drop_cnt=1), second packet output correctly.
- Full/wrap: AW=8, usedw held at 40, load 2 x 96-word packets. A third head arrives with free=64 -> dropped. Release all, then stream 10 x 64-word packets -> pointers wrap, all data correct, ov_pkt_cnt=12.
- i_rst asserted mid-output of a 20-word packet -> next cycle o_data_wr=0 and all outputs 0. A new packet after reset is handled normally.

Source files
------------

// File: rtl/pkt_egress_buffer.sv
// Store-and-forward egress buffer: admits whole packets into a RAM ring and
// releases one only when the port FIFO has room for a maximum-size packet.
module pkt_egress_buffer #(
  parameter int AW            = 8,
  parameter int MAX_PKT_WORDS = 96,
  parameter int USEDW_THRESH  = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [133:0]  iv_data,
  input  logic          i_data_wr,
  output logic [133:0]  ov_data,
  output logic          o_data_wr,
  input  logic [6:0]    iv_fifo_usedw,
  input  logic          i_cnt_rst,
  output logic [31:0]   ov_pkt_cnt,
  output logic [31:0]   ov_drop_cnt,
  output logic [AW-1:0] ov_pkt_avail,
  output logic [2:0]    ov_dbg_state
);

  // Handshake: i_data_wr qualifies iv_data and o_data_wr qualifies ov_data for
  // exactly one cycle each; there is no ready, flow control is the usedw check
  // made once at packet start.

  localparam int              DEPTH    = 1 << AW;
  localparam int              CW       = $clog2(MAX_PKT_WORDS);
  localparam logic [AW:0]     DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW:0]     MAX_W    = (AW+1)'(MAX_PKT_WORDS);
  localparam logic [AW:0]     PTR_ONE  = (AW+1)'(1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   LAST_MID = CW'(MAX_PKT_WORDS - 1);
  localparam logic [6:0]      THRESH_W = 7'(USEDW_THRESH);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACCEPT = 2'd1, W_DROP = 2'd2} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_SEND = 1'b1} rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic [133:0]  r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr, r_wr_commit, r_rd_ptr;
  logic [CW-1:0] r_wcnt;
  logic [133:0]  r_data;
  logic          r_data_wr;
  logic [31:0]   r_pkt_cnt, r_drop_cnt;
  logic [AW-1:0] r_pkt_avail;

  logic          w_head, w_mid, w_tail;
  logic [AW:0]   w_used, w_free;
  logic          w_fits;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_waddr;
  logic [AW:0]   w_wr_ptr_nxt;
  logic [CW-1:0] w_wcnt_nxt;
  logic          w_commit;
  logic [1:0]    w_drop_inc;
  logic          w_start, w_rd_en, w_release, w_out_tail;

  assign w_head = i_data_wr && (iv_data[133:132] == 2'b01);
  assign w_mid  = i_data_wr && (iv_data[133:132] == 2'b11);
  assign w_tail = i_data_wr && (iv_data[133:132] == 2'b10);

  // A head is always judged against the committed pointer, which is where the
  // working pointer lands after any rewind of an unfinished packet.
  assign w_used = r_wr_commit - r_rd_ptr;
  assign w_free = DEPTH_W - w_used;
  assign w_fits = (w_free >= MAX_W);

  // ---------------- write FSM ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) r_wstate <= W_IDLE;
    else       r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (w_head) w_wstate_nxt = w_fits ? W_ACCEPT : W_DROP;
      end
      W_ACCEPT: begin
        if (w_head)                              w_wstate_nxt = w_fits ? W_ACCEPT : W_DROP;
        else if (w_tail)                         w_wstate_nxt = W_IDLE;
        else if (w_mid && (r_wcnt == LAST_MID))  w_wstate_nxt = W_DROP;
      end
      W_DROP: begin
        if (w_head)      w_wstate_nxt = w_fits ? W_ACCEPT : W_DROP;
        else if (w_tail) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_ram_we     = 1'b0;
    w_ram_waddr  = r_wr_ptr[AW-1:0];
    w_wr_ptr_nxt = r_wr_ptr;
    w_wcnt_nxt   = r_wcnt;
    w_commit     = 1'b0;
    w_drop_inc   = 2'd0;
    if (w_head) begin
      // An unterminated packet in progress is dropped before the new head is judged.
      if (r_wstate == W_ACCEPT) w_drop_inc = 2'd1;
      if (w_fits) begin
        w_ram_we     = 1'b1;
        w_ram_waddr  = r_wr_commit[AW-1:0];
        w_wr_ptr_nxt = r_wr_commit + PTR_ONE;
        w_wcnt_nxt   = CNT_ONE;
      end else begin
        w_wr_ptr_nxt = r_wr_commit;
        w_drop_inc   = w_drop_inc + 2'd1;
      end
    end else if (r_wstate == W_ACCEPT) begin
      if (w_mid) begin
        if (r_wcnt == LAST_MID) begin
          // This word would fill the maximum length without a tail.
          w_wr_ptr_nxt = r_wr_commit;
          w_drop_inc   = 2'd1;
        end else begin
          w_ram_we     = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
          w_wcnt_nxt   = r_wcnt + CNT_ONE;
        end
      end else if (w_tail) begin
        w_ram_we     = 1'b1;
        w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
        w_commit     = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_ram_we) r_mem[w_ram_waddr] <= iv_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_wcnt      <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_wcnt   <= w_wcnt_nxt;
      if (w_commit) r_wr_commit <= r_wr_ptr + PTR_ONE;
    end
  end

  // ---------------- read FSM ----------------
  // The registered RAM output is the port output, so the tail is recognised
  // the cycle it is emitted and the read that would overrun it is suppressed.
  assign w_out_tail = r_data_wr && (r_data[133:132] == 2'b10);
  assign w_start    = (r_pkt_avail != '0) && (iv_fifo_usedw < THRESH_W);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_start)    w_rstate_nxt = R_SEND;
      R_SEND:  if (w_out_tail) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en   = 1'b0;
    w_release = 1'b0;
    case (r_rstate)
      R_IDLE:  w_rd_en = w_start;
      R_SEND: begin
        w_rd_en   = !w_out_tail;
        w_release = w_out_tail;
      end
      default: w_rd_en = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr  <= '0;
      r_data    <= '0;
      r_data_wr <= 1'b0;
    end else begin
      r_data_wr <= w_rd_en;
      r_data    <= w_rd_en ? r_mem[r_rd_ptr[AW-1:0]] : '0;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // ---------------- bookkeeping ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pkt_avail <= '0;
    end else begin
      case ({w_commit, w_release})
        2'b10:   r_pkt_avail <= r_pkt_avail + 1'b1;
        2'b01:   r_pkt_avail <= r_pkt_avail - 1'b1;
        default: r_pkt_avail <= r_pkt_avail;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_cnt_rst) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_pkt_cnt  <= r_pkt_cnt + 32'(w_release);
      r_drop_cnt <= r_drop_cnt + 32'(w_drop_inc);
    end
  end

  assign ov_data      = r_data;
  assign o_data_wr    = r_data_wr;
  assign ov_pkt_cnt   = r_pkt_cnt;
  assign ov_drop_cnt  = r_drop_cnt;
  assign ov_pkt_avail = r_pkt_avail;
  assign ov_dbg_state = {1'(r_rstate), 2'(r_wstate)};

endmodule

// File: tb/tb_pkt_egress_buffer.sv
// Bench for pkt_egress_buffer: cycle table for the basic latency, directed
// corner sequences, then random packet traffic against a packet-level model.
module tb_pkt_egress_buffer;

  logic         clk = 1'b0;
  logic         i_rst;
  logic [133:0] iv_data;
  logic         i_data_wr;
  logic [133:0] ov_data;
  logic         o_data_wr;
  logic [6:0]   iv_fifo_usedw;
  logic         i_cnt_rst;
  logic [31:0]  ov_pkt_cnt;
  logic [31:0]  ov_drop_cnt;
  logic [7:0]   ov_pkt_avail;
  logic [2:0]   dbg_state;

  always #5 clk = ~clk;

  pkt_egress_buffer #(.AW(8), .MAX_PKT_WORDS(96), .USEDW_THRESH(32)) dut (
    .i_clk(clk), .i_rst(i_rst), .iv_data(iv_data), .i_data_wr(i_data_wr),
    .ov_data(ov_data), .o_data_wr(o_data_wr), .iv_fifo_usedw(iv_fifo_usedw),
    .i_cnt_rst(i_cnt_rst), .ov_pkt_cnt(ov_pkt_cnt), .ov_drop_cnt(ov_drop_cnt),
    .ov_pkt_avail(ov_pkt_avail), .ov_dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int m_pkt    = 0;
  int m_drop   = 0;

  logic [133:0] exp_q[$];
  logic [133:0] pend_q[$];
  bit           hold_exp = 1'b0;
  bit           mon_off  = 1'b0;
  bit           in_pkt   = 1'b0;
  bit           prev_tail = 1'b0;
  logic [133:0] mon_e;

  task automatic check(input string nm, input logic [133:0] got, input logic [133:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [133:0] mk(input logic [1:0] typ);
    return {typ, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive(input logic wr, input logic [133:0] d);
    i_data_wr = wr;
    iv_data   = d;
    @(posedge clk); #1;
  endtask

  task automatic flush();
    while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
  endtask

  task automatic send_pkt(input int n, input bit with_tail, input bit keep, input bit gaps);
    logic [1:0]   typ;
    logic [133:0] w;
    for (int i = 0; i < n; i++) begin
      typ = (i == 0) ? 2'b01 : ((with_tail && i == n - 1) ? 2'b10 : 2'b11);
      w = mk(typ);
      if (keep) pend_q.push_back(w);
      drive(1'b1, w);
      if (gaps && i != n - 1 && $urandom_range(0, 3) == 0) drive(1'b0, mk(2'b11));
    end
    i_data_wr = 1'b0;
    if (keep && !hold_exp) flush();
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !o_data_wr && ov_pkt_avail == 8'd0) break;
      @(posedge clk); #1;
    end
    check("drain_exp_q_empty", 134'(exp_q.size()), 134'(0));
    check("drain_avail", 134'(ov_pkt_avail), 134'(0));
  endtask

  task automatic check_counts(input string nm);
    check({nm, "_pkt_cnt"}, 134'(ov_pkt_cnt), 134'(m_pkt));
    check({nm, "_drop_cnt"}, 134'(ov_drop_cnt), 134'(m_drop));
  endtask

  // Output stream monitor: words must match the expected queue in order,
  // a packet is never interrupted and packets are separated by an idle cycle.
  always @(negedge clk) begin
    if (!mon_off && !i_rst) begin
      if (o_data_wr) begin
        check("gap_between_pkts", 134'(prev_tail), 134'(0));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word got=%h exp=none", ov_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_word", ov_data, mon_e);
        end
        in_pkt    = (ov_data[133:132] != 2'b10);
        prev_tail = !in_pkt;
      end else begin
        check("stall_inside_pkt", 134'(in_pkt), 134'(0));
        check("idle_data_zero", ov_data, 134'(0));
        in_pkt    = 1'b0;
        prev_tail = 1'b0;
      end
    end else begin
      in_pkt    = 1'b0;
      prev_tail = 1'b0;
    end
  end

  typedef struct {
    logic       in_wr;
    logic [1:0] in_typ;
    logic       exp_wr;
    int         exp_idx;
    logic [7:0] exp_avail;
  } vec_t;

  vec_t         vt[11];
  logic [133:0] pw[4];
  logic [133:0] exp_word;

  initial begin
    #900us;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit prev_hi;
    int kind;
    int len;

    i_rst = 1'b1; i_data_wr = 1'b0; iv_data = '0; iv_fifo_usedw = 7'd0; i_cnt_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    check("rst_o_data_wr", 134'(o_data_wr), 134'(0));
    check("rst_ov_data", ov_data, 134'(0));
    check_counts("rst");
    check("rst_avail", 134'(ov_pkt_avail), 134'(0));

    // Single 4-word packet, tail in cycle 3, output in cycles 5..8.
    vt[0]  = '{1'b1, 2'b01, 1'b0, -1, 8'd0};
    vt[1]  = '{1'b1, 2'b11, 1'b0, -1, 8'd0};
    vt[2]  = '{1'b1, 2'b11, 1'b0, -1, 8'd0};
    vt[3]  = '{1'b1, 2'b10, 1'b0, -1, 8'd0};
    vt[4]  = '{1'b0, 2'b00, 1'b0, -1, 8'd1};
    vt[5]  = '{1'b0, 2'b00, 1'b1,  0, 8'd1};
    vt[6]  = '{1'b0, 2'b00, 1'b1,  1, 8'd1};
    vt[7]  = '{1'b0, 2'b00, 1'b1,  2, 8'd1};
    vt[8]  = '{1'b0, 2'b00, 1'b1,  3, 8'd1};
    vt[9]  = '{1'b0, 2'b00, 1'b0, -1, 8'd0};
    vt[10] = '{1'b0, 2'b00, 1'b0, -1, 8'd0};
    k = 0;
    for (int i = 0; i < 11; i++) if (vt[i].in_wr) begin pw[k] = mk(vt[i].in_typ); k++; end
    for (int i = 0; i < 4; i++) exp_q.push_back(pw[i]);
    k = 0;
    for (int i = 0; i < 11; i++) begin
      i_data_wr = vt[i].in_wr;
      if (vt[i].in_wr) begin iv_data = pw[k]; k++; end
      else iv_data = mk(2'b01);
      exp_word = (vt[i].exp_idx < 0) ? 134'(0) : pw[vt[i].exp_idx];
      check($sformatf("tbl_wr_c%0d", i), 134'(o_data_wr), 134'(vt[i].exp_wr));
      check($sformatf("tbl_data_c%0d", i), ov_data, exp_word);
      check($sformatf("tbl_avail_c%0d", i), 134'(ov_pkt_avail), 134'(vt[i].exp_avail));
      @(posedge clk); #1;
    end
    i_data_wr = 1'b0;
    m_pkt = 1;
    check_counts("single");

    // Backpressure: two packets held while usedw is at or above the threshold.
    iv_fifo_usedw = 7'd40;
    hold_exp = 1'b1;
    send_pkt(5, 1'b1, 1'b1, 1'b0);
    drive(1'b0, '0);
    drive(1'b0, '0);
    send_pkt(3, 1'b1, 1'b1, 1'b0);
    repeat (10) drive(1'b0, '0);
    check("bp_avail_held", 134'(ov_pkt_avail), 134'(2));
    check("bp_no_output", 134'(o_data_wr), 134'(0));
    hold_exp = 1'b0;
    flush();
    iv_fifo_usedw = 7'd31;
    wait_drain(200);
    m_pkt += 2;
    check_counts("bp");

    // Oversize packet is dropped whole, the next one survives the rewind.
    iv_fifo_usedw = 7'd0;
    send_pkt(100, 1'b1, 1'b0, 1'b0);
    send_pkt(4, 1'b1, 1'b1, 1'b0);
    wait_drain(200);
    m_drop += 1; m_pkt += 1;
    check_counts("oversize");

    // Malformed: a head arrives before the fragment's tail.
    send_pkt(3, 1'b0, 1'b0, 1'b0);
    send_pkt(4, 1'b1, 1'b1, 1'b0);
    wait_drain(200);
    m_drop += 1; m_pkt += 1;
    check_counts("malformed");

    // Statistics clear.
    i_cnt_rst = 1'b1;
    drive(1'b0, '0);
    i_cnt_rst = 1'b0;
    m_pkt = 0; m_drop = 0;
    check_counts("cnt_rst");

    // Fill: two max packets leave 64 free, so a third head is refused; then wrap.
    iv_fifo_usedw = 7'd40;
    hold_exp = 1'b1;
    send_pkt(96, 1'b1, 1'b1, 1'b0);
    send_pkt(96, 1'b1, 1'b1, 1'b0);
    send_pkt(96, 1'b1, 1'b0, 1'b0);
    m_drop += 1;
    drive(1'b0, '0);
    check("full_avail", 134'(ov_pkt_avail), 134'(2));
    check("full_drop_cnt", 134'(ov_drop_cnt), 134'(m_drop));
    hold_exp = 1'b0;
    flush();
    iv_fifo_usedw = 7'd0;
    wait_drain(600);
    for (int p = 0; p < 10; p++) send_pkt(64, 1'b1, 1'b1, 1'b0);
    wait_drain(1500);
    m_pkt += 12;
    check_counts("wrap");

    // Reset in the middle of a 20-word packet on the output.
    mon_off = 1'b1;
    send_pkt(20, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if (o_data_wr) break;
      @(posedge clk); #1;
    end
    check("rst_mid_started", 134'(o_data_wr), 134'(1));
    repeat (3) drive(1'b0, '0);
    i_rst = 1'b1;
    drive(1'b0, '0);
    i_rst = 1'b0;
    m_pkt = 0; m_drop = 0;
    check("rst_mid_wr", 134'(o_data_wr), 134'(0));
    check("rst_mid_data", ov_data, 134'(0));
    check("rst_mid_avail", 134'(ov_pkt_avail), 134'(0));
    check_counts("rst_mid");
    mon_off = 1'b0;
    send_pkt(4, 1'b1, 1'b1, 1'b0);
    wait_drain(200);
    m_pkt += 1;
    check_counts("after_rst");

    // Random traffic: good, oversize and truncated packets with stray words.
    prev_hi = 1'b0;
    for (int p = 0; p < 60; p++) begin
      kind = (p == 59) ? 5 : int'($urandom_range(0, 9));
      if (!prev_hi && $urandom_range(0, 4) == 0) begin
        iv_fifo_usedw = 7'($urandom_range(32, 127)); prev_hi = 1'b1;
      end else begin
        iv_fifo_usedw = 7'($urandom_range(0, 31)); prev_hi = 1'b0;
      end
      if (kind == 0) begin
        send_pkt(int'($urandom_range(97, 100)), 1'b1, 1'b0, 1'b1);
        m_drop++;
      end else if (kind == 1) begin
        send_pkt(int'($urandom_range(1, 5)), 1'b0, 1'b0, 1'b1);
        m_drop++;
      end else begin
        len = ($urandom_range(0, 15) == 0) ? 96 : int'($urandom_range(2, 24));
        send_pkt(len, 1'b1, 1'b1, 1'b1);
        m_pkt++;
      end
      for (int g = 0; g < int'($urandom_range(2, 4)); g++) begin
        if (kind != 1 && $urandom_range(0, 3) == 0)
          drive(1'b1, mk($urandom_range(0, 1) ? 2'b11 : 2'b10));
        else
          drive(1'b0, mk(2'($urandom_range(0, 3))));
      end
      i_data_wr = 1'b0;
    end
    iv_fifo_usedw = 7'd0;
    wait_drain(5000);
    check_counts("random");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
